// File: rtl/round_pkg.sv
// Shared definitions for the round_sat rounding/saturation stage:
// rounding-mode encodings and the pre-shift sum width helper.
package round_pkg;

  localparam logic [1:0] RND_TRUNC      = 2'd0;
  localparam logic [1:0] RND_HALF_UP    = 2'd1;
  localparam logic [1:0] RND_CONVERGENT = 2'd2;
  localparam logic [1:0] RND_HALF_AWAY  = 2'd3;

  // One guard bit above the input so the rounding bias can never wrap.
  function automatic int sum_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/round_sat_lane.sv
// One lane of round_sat: bias add into the stage-1 register, then
// arithmetic shift and signed clip into the output register.
module round_sat_lane
  import round_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic             mclk,
  input  logic             i_rst_n,
  input  logic             en1,
  input  logic             en2,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam int SW = sum_w(IN_W);
  localparam int WW = SW + OUT_W;
  localparam logic signed [WW-1:0] QMAX =
    signed'({{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [WW-1:0] QMIN =
    signed'({{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  logic [SW-1:0]        bias;
  logic signed [SW-1:0] sum_d, sum_q;
  logic signed [WW-1:0] sx, q;
  logic [OUT_W-1:0]     dout_d;
  logic                 ovf_d;

  generate
    if (SHIFT == 0) begin : g_nobias
      logic unused_mode;
      assign unused_mode = ^mode;
      assign bias = '0;
    end else begin : g_bias
      localparam logic [SW-1:0] HALF = SW'(1) << (SHIFT-1);
      always_comb begin
        bias = '0;
        case (mode)
          RND_TRUNC:      bias = '0;
          RND_HALF_UP:    bias = HALF;
          // kept LSB set -> 100..0, clear -> 011..1: ties land on even
          RND_CONVERGENT: bias = HALF - {{(SW-1){1'b0}}, ~din[SHIFT]};
          RND_HALF_AWAY:  bias = HALF - {{(SW-1){1'b0}}, din[IN_W-1]};
          default:        bias = '0;
        endcase
      end
    end
  endgenerate

  assign sum_d = $signed({din[IN_W-1], din}) + $signed(bias);

  always_comb begin
    sx     = {{OUT_W{sum_q[SW-1]}}, sum_q};
    q      = sx >>> SHIFT;
    dout_d = q[OUT_W-1:0];
    ovf_d  = 1'b0;
    if (q > QMAX) begin
      dout_d = QMAX[OUT_W-1:0];
      ovf_d  = 1'b1;
    end else if (q < QMIN) begin
      dout_d = QMIN[OUT_W-1:0];
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (en1) sum_q <= sum_d;
      if (en2) begin
        dout <= dout_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: rtl/round_sat.sv
// Multi-lane round + saturate stage with valid/ready, two-deep pipeline.
// ROUND_SAT_OVF_CNT_EN builds the saturating overflow-beat counter.
module round_sat
  import round_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int CH    = 2,
  parameter int CNT_W = 16
) (
  input  logic                mclk,
  input  logic                i_rst_n,
  input  logic                i_init,
  input  logic                i_vld,
  output logic                o_rdy,
  input  logic [1:0]          i_mode,
  input  logic [CH*IN_W-1:0]  i_data,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic [CH*OUT_W-1:0] o_data,
  output logic [CH-1:0]       o_ovf,
  output logic [CNT_W-1:0]    o_ovf_cnt
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            en1, en2;

  assign en2   = ~vld_pipe[2] | i_rdy;
  assign en1   = ~vld_pipe[1] | en2;
  assign o_rdy = en1 & ~i_init;
  assign o_vld = vld_pipe[2];

  // Bubbles still advance; a beat offered during init is lost with the flush.
  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
    end else if (i_init) begin
      vld_pipe <= '0;
    end else begin
      if (en1) vld_pipe[1] <= i_vld;
      if (en2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  generate
    for (genvar l = 0; l < CH; l++) begin : g_lane
      round_sat_lane #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
      ) u_lane (
        .mclk   (mclk),
        .i_rst_n(i_rst_n),
        .en1    (en1),
        .en2    (en2),
        .mode   (i_mode),
        .din    (i_data[l*IN_W +: IN_W]),
        .dout   (o_data[l*OUT_W +: OUT_W]),
        .ovf    (o_ovf[l])
      );
    end
  endgenerate

`ifdef ROUND_SAT_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt;

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt <= '0;
    end else if (i_init) begin
      ovf_cnt <= '0;
    end else if (o_vld && i_rdy && (|o_ovf) && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign o_ovf_cnt = ovf_cnt;
`else
  assign o_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_round_sat.sv
// Self-checking bench for round_sat: two narrow instances (SHIFT 4 / 2) for
// rounding and clipping, one default instance for flow control and init/reset.
module tb_round_sat;

`ifdef ROUND_SAT_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  // narrow instances share their inputs
  logic       s_init, s_vld, s_rdy;
  logic [1:0] s_mode;
  logic [7:0] s_data;
  logic       a_rdy, a_vld, b_rdy, b_vld;
  logic [3:0] a_data, b_data;
  logic [0:0] a_ovf, b_ovf;
  logic [1:0] a_cnt;
  logic [15:0] b_cnt;

  logic        d_init, d_vld, d_rdy, d_ordy, d_ovld;
  logic [1:0]  d_mode, d_ovf;
  logic [47:0] d_data;
  logic [31:0] d_odata;
  logic [15:0] d_cnt;

  round_sat #(.IN_W(8), .OUT_W(4), .SHIFT(4), .CH(1), .CNT_W(2)) u_a (
    .mclk(mclk), .i_rst_n(rst_n), .i_init(s_init), .i_vld(s_vld), .o_rdy(a_rdy),
    .i_mode(s_mode), .i_data(s_data), .o_vld(a_vld), .i_rdy(s_rdy),
    .o_data(a_data), .o_ovf(a_ovf), .o_ovf_cnt(a_cnt));

  round_sat #(.IN_W(8), .OUT_W(4), .SHIFT(2), .CH(1), .CNT_W(16)) u_b (
    .mclk(mclk), .i_rst_n(rst_n), .i_init(s_init), .i_vld(s_vld), .o_rdy(b_rdy),
    .i_mode(s_mode), .i_data(s_data), .o_vld(b_vld), .i_rdy(s_rdy),
    .o_data(b_data), .o_ovf(b_ovf), .o_ovf_cnt(b_cnt));

  round_sat u_d (
    .mclk(mclk), .i_rst_n(rst_n), .i_init(d_init), .i_vld(d_vld), .o_rdy(d_ordy),
    .i_mode(d_mode), .i_data(d_data), .o_vld(d_ovld), .i_rdy(d_rdy),
    .o_data(d_odata), .o_ovf(d_ovf), .o_ovf_cnt(d_cnt));

  int vec = 0, errs = 0;
  int ca = 0, cb = 0, cd = 0;
  logic [16:0] qa[$], qb[$];
  logic [33:0] qd[$];

  // Reference rounding from floor + remainder, then clip: {ovf, value[15:0]}.
  function automatic logic [16:0] ref_lane(input int x, input int sh, input int outw,
                                           input logic [1:0] m);
    int fl, fr, half, r, mx, mn;
    logic ov;
    if (sh == 0) r = x;
    else begin
      fl = x >>> sh;
      fr = x - (fl <<< sh);
      half = 1 << (sh - 1);
      case (m)
        2'd0: r = fl;
        2'd1: r = fl + ((fr >= half) ? 1 : 0);
        2'd2: r = fl + (((fr > half) || (fr == half && fl[0])) ? 1 : 0);
        default: r = (x < 0) ? fl + ((fr > half) ? 1 : 0) : fl + ((fr >= half) ? 1 : 0);
      endcase
    end
    mx = (1 << (outw - 1)) - 1;
    mn = -(1 << (outw - 1));
    ov = 1'b0;
    if (r > mx) begin r = mx; ov = 1'b1; end
    else if (r < mn) begin r = mn; ov = 1'b1; end
    return {ov, 16'(r)};
  endfunction

  function automatic logic [33:0] ref_big(input logic [47:0] v, input logic [1:0] m);
    logic [23:0] w0, w1;
    logic [16:0] l0, l1;
    w0 = v[23:0];
    w1 = v[47:24];
    l0 = ref_lane(int'($signed(w0)), 8, 16, m);
    l1 = ref_lane(int'($signed(w1)), 8, 16, m);
    return {l1[16], l0[16], l1[15:0], l0[15:0]};
  endfunction

  // Offers one beat to the narrow pair, returns just after the accepting edge.
  task automatic drive_small(input logic [1:0] m, input logic [7:0] v);
    @(negedge mclk);
    s_vld = 1'b1; s_mode = m; s_data = v;
    qa.push_back(ref_lane(int'($signed(v)), 4, 4, m));
    qb.push_back(ref_lane(int'($signed(v)), 2, 4, m));
    @(posedge mclk);
    #1 s_vld = 1'b0;
  endtask

  task automatic pulse_small_init();
    @(negedge mclk); s_init = 1'b1;
    @(posedge mclk); #1 s_init = 1'b0;
    ca = 0; cb = 0;
  endtask

  task automatic test_reset();
    @(negedge mclk);
    vec++;
    if ({a_vld, a_data, a_ovf, a_cnt, b_vld, b_data, b_ovf, b_cnt} !== '0) begin
      errs++; $display("FAIL reset_small got a=%b/%h/%b/%0d b=%b/%h/%b/%0d want zeros",
                       a_vld, a_data, a_ovf, a_cnt, b_vld, b_data, b_ovf, b_cnt);
    end
    vec++;
    if ({d_ovld, d_odata, d_ovf, d_cnt} !== '0) begin
      errs++; $display("FAIL reset_big got vld=%b d=%h ovf=%b cnt=%0d want zeros",
                       d_ovld, d_odata, d_ovf, d_cnt);
    end
    vec++;
    if (a_rdy !== 1'b1 || d_ordy !== 1'b1) begin
      errs++; $display("FAIL reset_rdy got a=%b d=%b want 1 1", a_rdy, d_ordy);
    end
  endtask

  task automatic test_modes();
    logic [7:0] ins [3];
    logic [1:0] mo [4];
    logic [16:0] ea, eb;
    ins = '{8'h18, 8'h28, 8'hE8};
    mo  = '{2'd2, 2'd1, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive_small(mo[k], ins[i]);
        @(posedge mclk); @(negedge mclk);
        ea = qa.pop_front(); eb = qb.pop_front();
        if (ea[16]) ca = (ca < 3) ? ca + 1 : 3;
        if (eb[16]) cb = cb + 1;
        vec++;
        if (a_vld !== 1'b1 || a_data !== ea[3:0] || a_ovf[0] !== ea[16]) begin
          errs++; $display("FAIL modes_s4 m=%0d in=%h got vld=%b d=%h ovf=%b want d=%h ovf=%b",
                           mo[k], ins[i], a_vld, a_data, a_ovf, ea[3:0], ea[16]);
        end
        vec++;
        if (b_vld !== 1'b1 || b_data !== eb[3:0] || b_ovf[0] !== eb[16]) begin
          errs++; $display("FAIL modes_s2 m=%0d in=%h got vld=%b d=%h ovf=%b want d=%h ovf=%b",
                           mo[k], ins[i], b_vld, b_data, b_ovf, eb[3:0], eb[16]);
        end
      end
    end
  endtask

  task automatic test_sat();
    logic [7:0] ins [3];
    logic [16:0] ea, eb;
    ins = '{8'h7F, 8'h80, 8'h14};
    pulse_small_init();
    for (int i = 0; i < 3; i++) begin
      drive_small(2'd0, ins[i]);
      @(posedge mclk); @(negedge mclk);
      ea = qa.pop_front(); eb = qb.pop_front();
      if (ea[16]) ca = (ca < 3) ? ca + 1 : 3;
      if (eb[16]) cb = cb + 1;
      vec++;
      if (b_vld !== 1'b1 || b_data !== eb[3:0] || b_ovf[0] !== eb[16]) begin
        errs++; $display("FAIL sat_s2 in=%h got vld=%b d=%h ovf=%b want d=%h ovf=%b",
                         ins[i], b_vld, b_data, b_ovf, eb[3:0], eb[16]);
      end
      vec++;
      if (a_vld !== 1'b1 || a_data !== ea[3:0] || a_ovf[0] !== ea[16]) begin
        errs++; $display("FAIL sat_s4 in=%h got vld=%b d=%h ovf=%b want d=%h ovf=%b",
                         ins[i], a_vld, a_data, a_ovf, ea[3:0], ea[16]);
      end
    end
    @(negedge mclk);
    vec++;
    if (b_cnt !== 16'(CNT_EN ? cb : 0)) begin
      errs++; $display("FAIL sat_cnt got %0d want %0d", b_cnt, CNT_EN ? cb : 0);
    end
  endtask

  task automatic test_carry();
    logic [16:0] ea, eb;
    pulse_small_init();
    drive_small(2'd1, 8'h7F);
    @(posedge mclk); @(negedge mclk);
    ea = qa.pop_front(); eb = qb.pop_front();
    vec++;
    if (a_vld !== 1'b1 || a_data !== 4'h7 || a_ovf[0] !== 1'b1 || ea[16] !== 1'b1) begin
      errs++; $display("FAIL carry got vld=%b d=%h ovf=%b want d=7 ovf=1 (model ovf=%b)",
                       a_vld, a_data, a_ovf, ea[16]);
    end
    vec++;
    if (b_data !== eb[3:0] || b_ovf[0] !== eb[16]) begin
      errs++; $display("FAIL carry_s2 got d=%h ovf=%b want d=%h ovf=%b",
                       b_data, b_ovf, eb[3:0], eb[16]);
    end
  endtask

  task automatic test_cnt_limit();
    logic [16:0] ea, eb;
    @(negedge mclk); s_init = 1'b1;
    #1;
    vec++;
    if (a_rdy !== 1'b0) begin
      errs++; $display("FAIL init_rdy_small got %b want 0", a_rdy);
    end
    @(posedge mclk); #1 s_init = 1'b0;
    ca = 0; cb = 0;
    @(negedge mclk);
    vec++;
    if (a_cnt !== 2'd0 || b_cnt !== 16'd0) begin
      errs++; $display("FAIL init_cnt_small got %0d %0d want 0 0", a_cnt, b_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      drive_small(2'd1, 8'h7F);
      @(posedge mclk); @(negedge mclk);
      ea = qa.pop_front(); eb = qb.pop_front();
      if (ea[16]) ca = (ca < 3) ? ca + 1 : 3;
      if (eb[16]) cb = cb + 1;
      vec++;
      if (a_vld !== 1'b1 || a_ovf[0] !== ea[16]) begin
        errs++; $display("FAIL cnt_beat i=%0d got vld=%b ovf=%b want 1 %b", i, a_vld, a_ovf, ea[16]);
      end
    end
    @(negedge mclk);
    vec++;
    if (a_cnt !== 2'(CNT_EN ? ca : 0)) begin
      errs++; $display("FAIL cnt_limit got %0d want %0d", a_cnt, CNT_EN ? ca : 0);
    end
    vec++;
    if (b_cnt !== 16'(CNT_EN ? cb : 0)) begin
      errs++; $display("FAIL cnt_wide got %0d want %0d", b_cnt, CNT_EN ? cb : 0);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0, infl = 0;
    logic acc = 1'b0, hold = 1'b0, ers;
    logic [31:0] hd;
    logic [1:0]  ho;
    logic [33:0] e;
    while (got < 10 && cyc < 300) begin
      @(negedge mclk); cyc++;
      if (acc) d_vld = 1'b0;
      acc = 1'b0;
      d_rdy = 1'($urandom_range(0, 1));
      if (!d_vld && sent < 10 && $urandom_range(0, 3) != 0) begin
        d_vld = 1'b1;
        d_mode = 2'($urandom_range(0, 3));
        d_data = {24'($urandom), 24'($urandom)};
        if (sent == 3) d_data = {24'h7FFFFF, 24'h800000};
      end
      #1;
      if (hold) begin
        vec++;
        if (d_ovld !== 1'b1 || d_odata !== hd || d_ovf !== ho) begin
          errs++; $display("FAIL bp_stall got vld=%b d=%h ovf=%b want 1 %h %b",
                           d_ovld, d_odata, d_ovf, hd, ho);
        end
      end
      ers = !(infl == 2 && !d_rdy);
      vec++;
      if (d_ordy !== ers) begin
        errs++; $display("FAIL bp_ordy infl=%0d rdy=%b got %b want %b", infl, d_rdy, d_ordy, ers);
      end
      if (d_ovld && d_rdy) begin
        vec++;
        if (qd.size() == 0) begin
          errs++; $display("FAIL bp_extra got beat d=%h want none", d_odata);
        end else begin
          e = qd.pop_front();
          if (|e[33:32]) cd = (cd < 65535) ? cd + 1 : 65535;
          if ({d_ovf, d_odata} !== e) begin
            errs++; $display("FAIL bp_data beat=%0d got %h/%h want %h/%h",
                             got, d_ovf, d_odata, e[33:32], e[31:0]);
          end
        end
        got++; infl--;
      end
      hold = d_ovld && !d_rdy;
      hd = d_odata; ho = d_ovf;
      if (d_vld && d_ordy) begin
        qd.push_back(ref_big(d_data, d_mode));
        sent++; infl++; acc = 1'b1;
      end
      @(posedge mclk);
    end
    if (got < 10) begin
      vec++; errs++;
      $display("FAIL bp_timeout got %0d beats want 10", got);
    end
    @(negedge mclk);
    d_vld = 1'b0; d_rdy = 1'b1;
    vec++;
    if (d_cnt !== 16'(CNT_EN ? cd : 0)) begin
      errs++; $display("FAIL bp_cnt got %0d want %0d", d_cnt, CNT_EN ? cd : 0);
    end
  endtask

  task automatic test_control();
    int n = 0, cyc = 0;
    logic [33:0] e;
    d_rdy = 1'b0;
    while (n < 2 && cyc < 10) begin
      @(negedge mclk); cyc++;
      d_vld = 1'b1; d_mode = 2'd1; d_data = {24'h7FFFFF, 24'h7FFFFF};
      #1 if (d_ordy) n++;
      @(posedge mclk);
    end
    @(negedge mclk); d_vld = 1'b0;
    #1;
    vec++;
    if (d_ordy !== 1'b0 || d_ovld !== 1'b1) begin
      errs++; $display("FAIL ctl_full got rdy=%b vld=%b want 0 1 (accepted %0d)", d_ordy, d_ovld, n);
    end
    @(negedge mclk); d_init = 1'b1; d_vld = 1'b1;
    #1;
    vec++;
    if (d_ordy !== 1'b0) begin
      errs++; $display("FAIL ctl_init_rdy got %b want 0", d_ordy);
    end
    @(posedge mclk); #1 d_init = 1'b0; d_vld = 1'b0; d_rdy = 1'b1;
    qd.delete(); cd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      vec++;
      if (d_ovld !== 1'b0 || d_cnt !== 16'd0) begin
        errs++; $display("FAIL ctl_flush c=%0d got vld=%b cnt=%0d want 0 0", i, d_ovld, d_cnt);
      end
    end
    @(negedge mclk); d_vld = 1'b1; d_mode = 2'd0; d_data = 48'h123456_654321;
    @(negedge mclk); d_data = 48'hABCDEF_FEDCBA;
    @(negedge mclk); d_vld = 1'b0; rst_n = 1'b0;
    #1;
    vec++;
    if ({d_ovld, d_odata, d_ovf, d_cnt} !== '0) begin
      errs++; $display("FAIL ctl_reset got vld=%b d=%h ovf=%b cnt=%0d want zeros",
                       d_ovld, d_odata, d_ovf, d_cnt);
    end
    @(negedge mclk); rst_n = 1'b1;
    @(negedge mclk); d_vld = 1'b1; d_mode = 2'd2; d_data = 48'h0A0180_FF7F80;
    e = ref_big(d_data, d_mode);
    @(posedge mclk); #1 d_vld = 1'b0;
    @(negedge mclk);
    vec++;
    if (d_ovld !== 1'b0) begin
      errs++; $display("FAIL ctl_lat1 got vld=%b want 0", d_ovld);
    end
    @(negedge mclk);
    vec++;
    if (d_ovld !== 1'b1 || {d_ovf, d_odata} !== e) begin
      errs++; $display("FAIL ctl_lat2 got vld=%b %h/%h want 1 %h/%h",
                       d_ovld, d_ovf, d_odata, e[33:32], e[31:0]);
    end
  endtask

  initial begin
    s_init = 1'b0; s_vld = 1'b0; s_rdy = 1'b1; s_mode = 2'd0; s_data = '0;
    d_init = 1'b0; d_vld = 1'b0; d_rdy = 1'b1; d_mode = 2'd0; d_data = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk) rst_n = 1'b1;
    test_reset();
    test_modes();
    test_sat();
    test_carry();
    test_cnt_limit();
    test_backpressure();
    test_control();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
